// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and bit-phase helpers for the I2C write master
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_DATA,
        ST_WAIT,
        ST_STOP,
        ST_FREE
    } ctrl_state_t;

    function automatic int unsigned qtr_of(input int unsigned div);
        return div / 4;
    endfunction

    function automatic int unsigned half_of(input int unsigned div);
        return div / 2;
    endfunction

    function automatic int unsigned tqtr_of(input int unsigned div);
        return (3 * div) / 4;
    endfunction

endpackage

// File: rtl/i2c_scl_gen.sv
// rtl/i2c_scl_gen.sv - bit-period counter, SCL drive and phase strobes
module i2c_scl_gen
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 500,
    parameter int unsigned DIV_LEN = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  ctrl_state_t        state_i,
    input  logic               clear_i,
    input  logic               freeze_i,
    output logic [DIV_LEN-1:0] cnt_o,
    output logic               period_end_o,
    output logic               ge_qtr_o,
    output logic               ge_tqtr_o,
    output logic               scl_oe_o
);

    localparam logic [DIV_LEN-1:0] LAST_CNT = DIV_LEN'(CLK_DIV - 1);
    localparam logic [DIV_LEN-1:0] QTR_CNT  = DIV_LEN'(qtr_of(CLK_DIV));
    localparam logic [DIV_LEN-1:0] HALF_CNT = DIV_LEN'(half_of(CLK_DIV));
    localparam logic [DIV_LEN-1:0] TQTR_CNT = DIV_LEN'(tqtr_of(CLK_DIV));

    logic [DIV_LEN-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (!freeze_i) begin
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o        = cnt_q;
    assign period_end_o = !clear_i && !freeze_i && (cnt_q == LAST_CNT);
    assign ge_qtr_o     = cnt_q >= QTR_CNT;
    assign ge_tqtr_o    = cnt_q >= TQTR_CNT;

    // START pulls SCL low late so the SDA fall lands while SCL is still high
    always_comb begin
        scl_oe_o = 1'b0;
        case (state_i)
            ST_START:                  scl_oe_o = cnt_q >= TQTR_CNT;
            ST_ADDR, ST_DATA, ST_STOP: scl_oe_o = cnt_q < HALF_CNT;
            ST_WAIT:                   scl_oe_o = 1'b1;
            default:                   scl_oe_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// rtl/i2c_master_ctrl.sv - I2C write-master sequencer: START, address, N data bytes, STOP
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned I2C_FREQ = 100_000,
    parameter int unsigned CLK_DIV  = CLK_FREQ / I2C_FREQ,
    parameter int unsigned DIV_LEN  = 16
) (
    input  logic               clk,
    input  logic               rstn,
    inout  wire                i2c_scl,
    inout  wire                i2c_sda,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [6:0]         cmd_addr,
    input  logic [7:0]         cmd_len,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [7:0]         wr_data,
    output logic               tx_n,
    output logic [7:0]         tx_data,
    output logic [DIV_LEN-1:0] clk_counter,
    input  logic               data_en_n,
    input  logic               ack_en_n,
    input  logic               ack_n,
    output logic               busy,
    output logic               done,
    output logic               nak
);

    ctrl_state_t state_q, state_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  rem_q, rem_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_n_q, tx_n_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        nak_q, nak_d;
    logic        ack_seen_q, ack_seen_d;
    logic        free_q, free_d;
    logic        wr_take;

    logic        period_end, ge_qtr, ge_tqtr, scl_oe, sda_oe;
    logic        ack_valid, nak_now;

    i2c_scl_gen #(
        .CLK_DIV (CLK_DIV),
        .DIV_LEN (DIV_LEN)
    ) u_scl_gen (
        .clk          (clk),
        .rstn         (rstn),
        .state_i      (state_q),
        .clear_i      (state_q == ST_IDLE),
        .freeze_i     (state_q == ST_WAIT),
        .cnt_o        (clk_counter),
        .period_end_o (period_end),
        .ge_qtr_o     (ge_qtr),
        .ge_tqtr_o    (ge_tqtr),
        .scl_oe_o     (scl_oe)
    );

    // Ack only counts once the transmitter has finished shifting the byte
    assign ack_valid = !ack_en_n && data_en_n;
    assign nak_now   = ack_seen_q ? nak_q : ack_n;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        tx_data_d  = tx_data_q;
        tx_n_d     = tx_n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        nak_d      = nak_q;
        ack_seen_d = ack_seen_q;
        free_d     = free_q;
        wr_take    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!free_q) begin
                    state_d = ST_FREE;
                end else if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    rem_d   = cmd_len;
                    nak_d   = 1'b0;
                    busy_d  = 1'b1;
                    free_d  = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (period_end) begin
                    tx_data_d  = {addr_q, 1'b0};
                    tx_n_d     = 1'b0;
                    ack_seen_d = 1'b0;
                    state_d    = ST_ADDR;
                end
            end
            ST_ADDR, ST_DATA: begin
                if (ack_valid && !ack_seen_q) begin
                    nak_d      = ack_n;
                    ack_seen_d = 1'b1;
                end
                if (period_end && ack_valid) begin
                    ack_seen_d = 1'b0;
                    if (nak_now || rem_q == 8'd0) begin
                        tx_n_d  = 1'b1;
                        state_d = ST_STOP;
                    end else if (wr_valid) begin
                        tx_data_d = wr_data;
                        wr_take   = 1'b1;
                        rem_d     = rem_q - 8'd1;
                        state_d   = ST_DATA;
                    end else begin
                        tx_n_d  = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wr_valid) begin
                    tx_data_d = wr_data;
                    wr_take   = 1'b1;
                    rem_d     = rem_q - 8'd1;
                    tx_n_d    = 1'b0;
                    state_d   = ST_DATA;
                end
            end
            ST_STOP: begin
                if (period_end) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_FREE;
                end
            end
            ST_FREE: begin
                if (period_end) begin
                    free_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            tx_data_q  <= 8'hFF;
            tx_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nak_q      <= 1'b0;
            ack_seen_q <= 1'b0;
            free_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            tx_data_q  <= tx_data_d;
            tx_n_q     <= tx_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            nak_q      <= nak_d;
            ack_seen_q <= ack_seen_d;
            free_q     <= free_d;
        end
    end

    assign sda_oe = (state_q == ST_START && ge_qtr) || (state_q == ST_STOP && !ge_tqtr);

    assign i2c_scl   = scl_oe ? 1'b0 : 1'bz;
    assign i2c_sda   = sda_oe ? 1'b0 : 1'bz;
    assign cmd_ready = (state_q == ST_IDLE) && free_q;
    assign wr_ready  = wr_take;
    assign tx_n      = tx_n_q;
    assign tx_data   = tx_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign nak       = nak_q;

endmodule
